// File: rtl/mux_tree_pkg.sv
// Shared sizing helpers and default parameters for the pipelined read-select mux tree.
package mux_tree_pkg;

  localparam int DEF_WIDTH  = 64;
  localparam int DEF_NUM_IN = 32;

  // Number of tree levels: one per select-bit pair, plus a 2:1 tail for an odd bit.
  function automatic int levels(input int sel_w);
    return (sel_w + 1) / 2;
  endfunction

  // Words remaining after n levels (n = 0 gives the input count).
  function automatic int stage_words(input int num_in, input int n);
    int w;
    w = num_in;
    for (int i = 0; i < n; i++) begin
      w = (w >= 4) ? w / 4 : 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/mux4_w.sv
// WIDTH-bit 4:1 word multiplexer used as the building block of each tree level.
module mux4_w #(
  parameter int WIDTH = 64
) (
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  input  logic [WIDTH-1:0] d2,
  input  logic [WIDTH-1:0] d3,
  input  logic [1:0]       sel,
  output logic [WIDTH-1:0] y
);

  always_comb begin
    y = d0;
    case (sel)
      2'd1:    y = d1;
      2'd2:    y = d2;
      2'd3:    y = d3;
      default: y = d0;
    endcase
  end

endmodule

// File: rtl/mux_tree_pipe.sv
// Pipelined NUM_IN:1 word select tree with a register after every 4:1 level and a global stall.
// Optional MUX_TREE_PIPE_ZERO_REG_EN makes index NUM_IN-1 read as zero.
module mux_tree_pipe
  import mux_tree_pkg::*;
#(
  parameter  int WIDTH  = DEF_WIDTH,
  parameter  int NUM_IN = DEF_NUM_IN,
  localparam int SEL_W  = $clog2(NUM_IN)
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]        in_sel,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_valid,
  input  logic                    out_ready
);

  localparam int LEVELS = levels(SEL_W);

  logic adv;

  // A stall anywhere freezes the whole pipe; bubbles are deliberately not squeezed out.
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  genvar gi, gj;
  for (gi = 0; gi < LEVELS; gi++) begin : gen_lvl
    localparam int IN_W     = stage_words(NUM_IN, gi);
    localparam int OUT_W    = stage_words(NUM_IN, gi + 1);
    localparam int SEL_IN_W = SEL_W - 2 * gi;
    localparam bit LAST     = (gi == LEVELS - 1);

    logic [WIDTH-1:0]    lvl_in  [IN_W];
    logic [WIDTH-1:0]    mux_out [OUT_W];
    logic [WIDTH-1:0]    data_reg [OUT_W];
    logic [SEL_IN_W-1:0] lvl_sel;
    logic                lvl_valid;
    logic                lvl_zero;
    logic                valid_reg;

    if (gi == 0) begin : g_src
      for (gj = 0; gj < IN_W; gj++) begin : g_word
        assign lvl_in[gj] = in_data[gj*WIDTH +: WIDTH];
      end
      assign lvl_sel   = in_sel;
      assign lvl_valid = in_valid;
`ifdef MUX_TREE_PIPE_ZERO_REG_EN
      assign lvl_zero  = (in_sel == SEL_W'(NUM_IN - 1));
`else
      assign lvl_zero  = 1'b0;
`endif
    end else begin : g_src
      assign lvl_in    = gen_lvl[gi-1].data_reg;
      assign lvl_sel   = gen_lvl[gi-1].g_fwd.sel_reg;
      assign lvl_valid = gen_lvl[gi-1].valid_reg;
      assign lvl_zero  = gen_lvl[gi-1].g_fwd.zero_reg;
    end

    if (SEL_IN_W >= 2) begin : g_mux4
      for (gj = 0; gj < OUT_W; gj++) begin : g_m
        mux4_w #(.WIDTH(WIDTH)) u_mux (
          .d0  (lvl_in[4*gj]),
          .d1  (lvl_in[4*gj+1]),
          .d2  (lvl_in[4*gj+2]),
          .d3  (lvl_in[4*gj+3]),
          .sel (lvl_sel[1:0]),
          .y   (mux_out[gj])
        );
      end
    end else begin : g_mux2
      assign mux_out[0] = lvl_sel[0] ? lvl_in[1] : lvl_in[0];
    end

    // Unconsumed select bits and the zero flag ride along with the request.
    if (!LAST) begin : g_fwd
      logic [SEL_IN_W-3:0] sel_reg;
      logic                zero_reg;
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          sel_reg  <= '0;
          zero_reg <= 1'b0;
        end else if (adv) begin
          sel_reg  <= lvl_sel[SEL_IN_W-1:2];
          zero_reg <= lvl_zero;
        end
      end
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        valid_reg <= 1'b0;
        for (int j = 0; j < OUT_W; j++) data_reg[j] <= '0;
      end else if (adv) begin
        valid_reg <= lvl_valid;
        for (int j = 0; j < OUT_W; j++) data_reg[j] <= (LAST && lvl_zero) ? '0 : mux_out[j];
      end
    end
  end

  assign out_valid = gen_lvl[LEVELS-1].valid_reg;
  assign out_data  = gen_lvl[LEVELS-1].data_reg[0];

endmodule

// File: tb/tb_mux_tree_pipe.sv
// Directed self-checking bench: a 32-input/64-bit instance and an 8-input/16-bit instance (2:1 tail).
module tb_mux_tree_pipe;

  localparam int N32 = 32;
  localparam int W32 = 64;
  localparam int N8  = 8;
  localparam int W8  = 16;
`ifdef MUX_TREE_PIPE_ZERO_REG_EN
  localparam bit ZERO_EN = 1'b1;
`else
  localparam bit ZERO_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  logic [N32*W32-1:0] a_data;
  logic [4:0]         a_sel;
  logic               a_valid, a_ready, a_ovalid, a_oready;
  logic [W32-1:0]     a_odata;

  logic [N8*W8-1:0]   b_data;
  logic [2:0]         b_sel;
  logic               b_valid, b_ready, b_ovalid, b_oready;
  logic [W8-1:0]      b_odata;

  int checks   = 0;
  int failures = 0;

  mux_tree_pipe #(.WIDTH(W32), .NUM_IN(N32)) dut_a (
    .clk(clk), .reset_n(reset_n), .in_data(a_data), .in_sel(a_sel), .in_valid(a_valid),
    .in_ready(a_ready), .out_data(a_odata), .out_valid(a_ovalid), .out_ready(a_oready)
  );

  mux_tree_pipe #(.WIDTH(W8), .NUM_IN(N8)) dut_b (
    .clk(clk), .reset_n(reset_n), .in_data(b_data), .in_sel(b_sel), .in_valid(b_valid),
    .in_ready(b_ready), .out_data(b_odata), .out_valid(b_ovalid), .out_ready(b_oready)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] a_exp(input int k);
    if (ZERO_EN && k == N32 - 1) return 64'h0;
    return 64'h1000 + 64'(k);
  endfunction

  initial begin
    reset_n  = 1'b0;
    a_sel    = '0;
    a_valid  = 1'b0;
    a_oready = 1'b1;
    b_sel    = '0;
    b_valid  = 1'b0;
    b_oready = 1'b1;
    for (int k = 0; k < N32; k++) a_data[k*W32 +: W32] = 64'h1000 + 64'(k);
    for (int k = 0; k < N8; k++)  b_data[k*W8 +: W8]   = 16'h2000 + 16'(k);

    // Reset state
    step();
    step();
    chk("reset_out_valid", 64'(a_ovalid), 64'h0);
    chk("reset_out_data", a_odata, 64'h0);
    chk("reset_in_ready", 64'(a_ready), 64'h1);
    chk("reset_b_out_valid", 64'(b_ovalid), 64'h0);

    // Test 1: single request sel=5, latency 3
    reset_n = 1'b1;
    a_sel   = 5'd5;
    a_valid = 1'b1;
    step();
    a_valid = 1'b0;
    chk("t1_valid_e1", 64'(a_ovalid), 64'h0);
    chk("t1_data_e1", a_odata, 64'h0);
    step();
    chk("t1_valid_e2", 64'(a_ovalid), 64'h0);
    chk("t1_data_e2", a_odata, 64'h0);
    step();
    chk("t1_valid_e3", 64'(a_ovalid), 64'h1);
    chk("t1_data_e3", a_odata, 64'h1005);
    step();
    chk("t1_valid_e4", 64'(a_ovalid), 64'h0);

    // Test 2: back-to-back sel 0..31
    for (int c = 0; c < N32 + 2; c++) begin
      a_valid = (c < N32);
      a_sel   = 5'(c);
      step();
      if (c >= 2) begin
        chk($sformatf("t2_valid_%0d", c - 2), 64'(a_ovalid), 64'h1);
        chk($sformatf("t2_data_%0d", c - 2), a_odata, a_exp(c - 2));
      end else begin
        chk($sformatf("t2_fill_%0d", c), 64'(a_ovalid), 64'h0);
      end
    end
    a_valid = 1'b0;
    step();
    chk("t2_drain", 64'(a_ovalid), 64'h0);

    // Test 3: backpressure with 3 at the output
    a_valid = 1'b1;
    a_sel = 5'd3; step();
    a_sel = 5'd7; step();
    a_sel = 5'd9; step();
    a_valid  = 1'b0;
    a_oready = 1'b0;
    #1;
    chk("t3_valid_hold", 64'(a_ovalid), 64'h1);
    chk("t3_data_hold", a_odata, 64'h1003);
    chk("t3_ready_low", 64'(a_ready), 64'h0);
    for (int c = 0; c < 4; c++) begin
      step();
      chk($sformatf("t3_stall_data_%0d", c), a_odata, 64'h1003);
      chk($sformatf("t3_stall_ready_%0d", c), 64'(a_ready), 64'h0);
      chk($sformatf("t3_stall_valid_%0d", c), 64'(a_ovalid), 64'h1);
    end
    a_oready = 1'b1;
    #1;
    chk("t3_ready_release", 64'(a_ready), 64'h1);
    step();
    chk("t3_data_7", a_odata, 64'h1007);
    chk("t3_valid_7", 64'(a_ovalid), 64'h1);
    step();
    chk("t3_data_9", a_odata, 64'h1009);
    chk("t3_valid_9", 64'(a_ovalid), 64'h1);
    step();
    chk("t3_drain", 64'(a_ovalid), 64'h0);

    // Test 4: data captured at accept
    a_sel   = 5'd12;
    a_valid = 1'b1;
    step();
    a_valid = 1'b0;
    a_data[12*W32 +: W32] = 64'hDEAD;
    step();
    step();
    chk("t4_valid", 64'(a_ovalid), 64'h1);
    chk("t4_data", a_odata, 64'h100C);
    a_data[12*W32 +: W32] = 64'h100C;

    // Test 5: top index / zero register
    a_data[31*W32 +: W32] = 64'hFFFF;
    a_sel   = 5'd31;
    a_valid = 1'b1;
    step();
    a_valid = 1'b0;
    step();
    step();
    chk("t5_valid", 64'(a_ovalid), 64'h1);
    chk("t5_data", a_odata, ZERO_EN ? 64'h0 : 64'hFFFF);
    a_data[31*W32 +: W32] = 64'h101F;

    // Test 6: reset with requests in flight
    a_valid = 1'b1;
    a_sel = 5'd1; step();
    a_sel = 5'd2; step();
    a_sel = 5'd3; step();
    a_valid = 1'b0;
    chk("t6_pre_valid", 64'(a_ovalid), 64'h1);
    reset_n = 1'b0;
    #1;
    chk("t6_async_valid", 64'(a_ovalid), 64'h0);
    chk("t6_async_data", a_odata, 64'h0);
    step();
    step();
    reset_n = 1'b1;
    #1;
    chk("t6_ready_after", 64'(a_ready), 64'h1);
    for (int c = 0; c < 3; c++) begin
      step();
      chk($sformatf("t6_no_stale_%0d", c), 64'(a_ovalid), 64'h0);
      chk($sformatf("t6_b_no_stale_%0d", c), 64'(b_ovalid), 64'h0);
    end

    // NUM_IN=8: two levels, 2:1 tail, latency 2
    b_sel   = 3'd6;
    b_valid = 1'b1;
    step();
    b_sel = 3'd3;
    chk("b_valid_e1", 64'(b_ovalid), 64'h0);
    step();
    b_valid = 1'b0;
    chk("b_valid_6", 64'(b_ovalid), 64'h1);
    chk("b_data_6", 64'(b_odata), 64'h2006);
    step();
    chk("b_valid_3", 64'(b_ovalid), 64'h1);
    chk("b_data_3", 64'(b_odata), 64'h2003);
    step();
    chk("b_drain", 64'(b_ovalid), 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
